// File: rtl/upc_pkg.sv
// Shared types and product-code map for the UPC scanner receiver.
package upc_pkg;

   // Receiver FSM states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } scan_state_t;

   // Product codes, same encoding the 7-segment decoder reads on SW[9:7]
   localparam logic [2:0] UPC_PHONES    = 3'b000;
   localparam logic [2:0] UPC_FRED      = 3'b001;
   localparam logic [2:0] UPC_HANDS     = 3'b011;
   localparam logic [2:0] UPC_PLANES    = 3'b100;
   localparam logic [2:0] UPC_ARTIFACTS = 3'b101;
   localparam logic [2:0] UPC_DOGFOOD   = 3'b110;
   localparam logic [2:0] UPC_NONE      = 3'b111;

   // High for codes that name a real product; 010 and 111 have no product
   function automatic logic is_known(input logic [2:0] code);
      logic known;
      case (code)
         UPC_PHONES, UPC_FRED, UPC_HANDS,
         UPC_PLANES, UPC_ARTIFACTS, UPC_DOGFOOD: known = 1'b1;
         default:                                known = 1'b0;
      endcase
      return known;
   endfunction

endpackage

// File: rtl/upc_scanner_sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops; reset value chosen so release never looks like an edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/upc_scanner.sv
// Serial receiver for framed 3-bit UPC codes: start, d0..d2 (LSB first),
// odd parity, stop. Holds the last good code for the display logic.
module upc_scanner
   import upc_pkg::*;
#(
   parameter int BIT_TICKS = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       scan_in,
   output logic [2:0] upc,
   output logic       upc_valid,
   output logic       upc_known,
   output logic       frame_err
);

   localparam int CW = $clog2(BIT_TICKS);
   // Mid-bit of the start bit, then one full bit period between samples
   localparam logic [CW-1:0] HALF_LAST = CW'(BIT_TICKS / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(BIT_TICKS - 1);

   logic        s;
   scan_state_t state_q, state_d;
   logic [CW-1:0] tick_q, tick_d;
   logic [1:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic [2:0]  upc_q, upc_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;

   sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (scan_in),
      .q_o     (s)
   );

   // Next-state logic: walk through the frame, sampling at bit centres
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      upc_d     = upc_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;

      case (state_q)
         IDLE: begin
            tick_d = '0;
            if (!s) begin
               state_d = START;
            end
         end

         START: begin
            if (tick_q == HALF_LAST) begin
               tick_d    = '0;
               bit_cnt_d = '0;
               // A line that is already high again was only a glitch
               state_d   = s ? IDLE : DATA;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end

         DATA: begin
            if (tick_q == FULL_LAST) begin
               tick_d  = '0;
               // LSB arrives first, so shift in from the top
               shift_d = {s, shift_q[2:1]};
               if (bit_cnt_q == 2'd2) begin
                  state_d = PARITY;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end

         PARITY: begin
            if (tick_q == FULL_LAST) begin
               tick_d  = '0;
               par_d   = s;
               state_d = STOP;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end

         STOP: begin
            if (tick_q == FULL_LAST) begin
               tick_d = '0;
               if (s) begin
                  state_d = IDLE;
                  // Odd parity: data bits plus parity must hold an odd count of ones
                  if (^{shift_q, par_q}) begin
                     upc_d   = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  // Stop bit low: treat as a break and wait for the line to recover
                  ferr_d  = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end

         WAIT_HIGH: begin
            tick_d = '0;
            if (s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            tick_d  = '0;
         end
      endcase
   end

   // State registers; reset from any point in a frame back to a clean idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         tick_q    <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         upc_q     <= UPC_NONE;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         upc_q     <= upc_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign upc       = upc_q;
   assign upc_known = is_known(upc_q);
   assign upc_valid = valid_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_upc_scanner.sv
// Directed bench for upc_scanner with BIT_TICKS = 16.
module tb_upc_scanner;
   import upc_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       scan_in = 1'b1;
   logic [2:0] upc;
   logic       upc_valid;
   logic       upc_known;
   logic       frame_err;

   int checks = 0;
   int passed = 0;
   int failed = 0;
   int cyc = 0;
   int both_seen = 0;
   int vq[$];
   int eq[$];
   int t1, t2;

   upc_scanner #(
      .BIT_TICKS (16)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .scan_in   (scan_in),
      .upc       (upc),
      .upc_valid (upc_valid),
      .upc_known (upc_known),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record the cycle of every pulse, sampled mid-cycle
   always @(negedge clk) begin
      if (upc_valid) vq.push_back(cyc);
      if (frame_err) eq.push_back(cyc);
      if (upc_valid && frame_err) both_seen++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Frame bits in line order: start, d0, d1, d2, parity, stop
   function automatic logic [5:0] frame(input logic [2:0] code, input logic flip, input logic stop);
      logic p;
      p = (~^code) ^ flip;
      return {stop, p, code[2], code[1], code[0], 1'b0};
   endfunction

   // Drive one frame, 16 cycles per bit; leaves the stop-bit level on the line
   task automatic send_frame(input logic [5:0] b, output int t_start);
      t_start = cyc;
      for (int k = 0; k < 6; k++) begin
         scan_in = b[k];
         repeat (16) @(posedge clk);
         #1;
      end
   endtask

   function automatic int first_of(input int q[$]);
      return (q.size() > 0) ? q[0] : -1000;
   endfunction

   initial begin
      // Power-on reset
      repeat (3) @(posedge clk);
      #1;
      check("rst_upc", upc, 3'b111);
      check("rst_known", upc_known, 0);
      check("rst_valid", upc_valid, 0);
      check("rst_ferr", frame_err, 0);
      reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // Reset hit in the middle of a frame
      scan_in = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("mid_state_data", dut.state_q, DATA);
      reset_n = 1'b0;
      #2;
      check("mid_rst_upc", upc, 3'b111);
      check("mid_rst_known", upc_known, 0);
      check("mid_rst_state", dut.state_q, IDLE);
      scan_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("mid_no_valid", vq.size(), 0);
      check("mid_no_ferr", eq.size(), 0);

      // Clean frame 001 after reset release
      send_frame(frame(3'b001, 1'b0, 1'b1), t1);
      check("f001_nvalid", vq.size(), 1);
      check("f001_time", first_of(vq) - t1, 91);
      check("f001_upc", upc, 3'b001);
      check("f001_known", upc_known, 1);
      check("f001_nferr", eq.size(), 0);
      repeat (10) @(posedge clk);
      #1;

      // Clean frame 101 (line bits 0,1,0,1,1,1)
      vq.delete(); eq.delete();
      send_frame(6'b111010, t1);
      check("f101_nvalid", vq.size(), 1);
      check("f101_time", first_of(vq) - t1, 91);
      check("f101_upc", upc, 3'b101);
      check("f101_known", upc_known, 1);
      check("f101_nferr", eq.size(), 0);
      repeat (10) @(posedge clk);
      #1;

      // Frame 011 with parity inverted
      vq.delete(); eq.delete();
      send_frame(frame(3'b011, 1'b1, 1'b1), t1);
      check("par_nferr", eq.size(), 1);
      check("par_time", first_of(eq) - t1, 91);
      check("par_nvalid", vq.size(), 0);
      check("par_upc_hold", upc, 3'b101);
      check("par_known_hold", upc_known, 1);
      repeat (10) @(posedge clk);
      #1;

      // Start glitch of 4 cycles, then a clean 110
      vq.delete(); eq.delete();
      scan_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      scan_in = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("glitch_state", dut.state_q, IDLE);
      check("glitch_nvalid", vq.size(), 0);
      check("glitch_nferr", eq.size(), 0);
      send_frame(frame(3'b110, 1'b0, 1'b1), t1);
      check("f110_nvalid", vq.size(), 1);
      check("f110_time", first_of(vq) - t1, 91);
      check("f110_upc", upc, 3'b110);
      check("f110_known", upc_known, 1);
      repeat (10) @(posedge clk);
      #1;

      // Stop bit low, line held low as a break
      vq.delete(); eq.delete();
      send_frame(frame(3'b001, 1'b0, 1'b0), t1);
      repeat (100) @(posedge clk);
      #1;
      check("brk_nferr", eq.size(), 1);
      check("brk_time", first_of(eq) - t1, 91);
      check("brk_nvalid", vq.size(), 0);
      check("brk_state", dut.state_q, WAIT_HIGH);
      check("brk_upc_hold", upc, 3'b110);
      scan_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("brk_recover_state", dut.state_q, IDLE);
      check("brk_nferr_after", eq.size(), 1);
      repeat (10) @(posedge clk);
      #1;

      // Back-to-back frames 100 then 010 with no idle gap
      vq.delete(); eq.delete();
      send_frame(frame(3'b100, 1'b0, 1'b1), t1);
      send_frame(frame(3'b010, 1'b0, 1'b1), t2);
      repeat (5) @(posedge clk);
      #1;
      check("b2b_nvalid", vq.size(), 2);
      check("b2b_time1", first_of(vq) - t1, 91);
      check("b2b_gap", (vq.size() > 1) ? vq[1] - vq[0] : -1, 96);
      check("b2b_upc", upc, 3'b010);
      check("b2b_known", upc_known, 0);
      check("b2b_nferr", eq.size(), 0);

      check("never_both", both_seen, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
